// File: rtl/lutram_ctrl_pkg.sv
// Shared constants, state type and the two-requester round-robin helper
// used by the LUTRAM port arbiter.
package lutram_ctrl_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    localparam int NREQ   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One-hot grant for two candidates: a lone candidate always wins; on
    // contention the requester named by ptr wins.
    function automatic logic [NREQ-1:0] rr_grant(input logic [NREQ-1:0] cand,
                                                 input logic            ptr);
        if (&cand) begin
            return ptr ? 2'b10 : 2'b01;
        end
        return cand;
    endfunction

endpackage

// File: rtl/lutram_bank.sv
// WIDTH-bit, 64-deep dual-port bank built from one RAM64X1D per data bit.
// Address, write enable and read address are shared; data is per bit.
module lutram_bank
    import lutram_ctrl_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string LOC   = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        if (LOC != "") begin : g_placed
            (* LOC = LOC *)
            RAM64X1D #(
                .INIT             (64'h0),
                .IS_WCLK_INVERTED (1'b0)
            ) u_ram (
                .DPO   (dout[b]),
                .A0    (addr[0]),    .A1 (addr[1]),    .A2 (addr[2]),
                .A3    (addr[3]),    .A4 (addr[4]),    .A5 (addr[5]),
                .D     (din[b]),
                .DPRA0 (rd_addr[0]), .DPRA1 (rd_addr[1]), .DPRA2 (rd_addr[2]),
                .DPRA3 (rd_addr[3]), .DPRA4 (rd_addr[4]), .DPRA5 (rd_addr[5]),
                .WCLK  (clk),
                .WE    (we)
            );
        end else begin : g_free
            RAM64X1D #(
                .INIT             (64'h0),
                .IS_WCLK_INVERTED (1'b0)
            ) u_ram (
                .DPO   (dout[b]),
                .A0    (addr[0]),    .A1 (addr[1]),    .A2 (addr[2]),
                .A3    (addr[3]),    .A4 (addr[4]),    .A5 (addr[5]),
                .D     (din[b]),
                .DPRA0 (rd_addr[0]), .DPRA1 (rd_addr[1]), .DPRA2 (rd_addr[2]),
                .DPRA3 (rd_addr[3]), .DPRA4 (rd_addr[4]), .DPRA5 (rd_addr[5]),
                .WCLK  (clk),
                .WE    (we)
            );
        end
    end

endmodule

// File: rtl/ram64x1d.sv
// Behavioural model of the 64x1 dual-port distributed RAM primitive for
// simulation builds. Write/A port is synchronous, the DPRA/DPO read port is
// asynchronous. The single-port read output is not modelled.
module RAM64X1D #(
    parameter logic [63:0] INIT             = 64'h0,
    parameter logic        IS_WCLK_INVERTED = 1'b0
) (
    output logic DPO,
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic A5,
    input  logic D,
    input  logic DPRA0,
    input  logic DPRA1,
    input  logic DPRA2,
    input  logic DPRA3,
    input  logic DPRA4,
    input  logic DPRA5,
    input  logic WCLK,
    input  logic WE
);

    // NOTE: storage cells have no reset; their power-up content is INIT and
    // the controller's clear sequence is what makes the bank known-zero.
    logic [63:0] mem = INIT;
    logic        wclk_int;

    assign wclk_int = WCLK ^ IS_WCLK_INVERTED;

    // Synchronous write through the A port.
    always_ff @(posedge wclk_int) begin
        if (WE) begin
            mem[{A5, A4, A3, A2, A1, A0}] <= D;
        end
    end

    assign DPO = mem[{DPRA5, DPRA4, DPRA3, DPRA2, DPRA1, DPRA0}];

endmodule

// File: rtl/lutram_port_arbiter.sv
// Shares one dual-port LUTRAM bank between two requesters: one write and one
// read granted per cycle, each with its own round-robin pointer, plus a
// zero-fill sequencer that runs after reset and on request.
module lutram_port_arbiter
    import lutram_ctrl_pkg::*;
#(
    parameter int    WIDTH = 8,
    parameter string LOC   = ""
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_we,
    input  logic [NREQ*ADDR_W-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [NREQ*WIDTH-1:0]   rsp_data,
    input  logic                    clear,
    output logic                    busy
);

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              rr_wr;
    logic              rr_rd;

    logic              take;
    logic [NREQ-1:0]   wr_cand;
    logic [NREQ-1:0]   rd_cand;
    logic [NREQ-1:0]   wr_gnt;
    logic [NREQ-1:0]   rd_gnt;

    logic              bank_we;
    logic [ADDR_W-1:0] bank_addr;
    logic [ADDR_W-1:0] bank_rd_addr;
    logic [WIDTH-1:0]  bank_din;
    logic [WIDTH-1:0]  bank_dout;

    // Grant selection: nothing is granted while clearing or in the cycle a
    // clear is requested.
    always_comb begin
        // NOTE: every combinational output gets a value on every path so no
        // latch is inferred.
        take    = (state == RUN) && !clear;
        wr_cand = req_valid & req_we;
        rd_cand = req_valid & ~req_we;
        wr_gnt  = '0;
        rd_gnt  = '0;
        if (take) begin
            wr_gnt = rr_grant(wr_cand, rr_wr);
            rd_gnt = rr_grant(rd_cand, rr_rd);
        end
    end

    assign req_ready = wr_gnt | rd_gnt;
    assign busy      = (state == CLEAR);

    // Bank port muxing: the clear sequencer owns the write port while busy.
    always_comb begin
        bank_we      = 1'b0;
        bank_addr    = req_addr[ADDR_W-1:0];
        bank_din     = req_wdata[WIDTH-1:0];
        bank_rd_addr = rd_gnt[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        if (state == CLEAR) begin
            bank_we   = 1'b1;
            bank_addr = clr_addr;
            bank_din  = '0;
        end else begin
            bank_we = |wr_gnt;
            if (wr_gnt[1]) begin
                bank_addr = req_addr[2*ADDR_W-1:ADDR_W];
                bank_din  = req_wdata[2*WIDTH-1:WIDTH];
            end
        end
    end

    lutram_bank #(
        .WIDTH (WIDTH),
        .LOC   (LOC)
    ) u_bank (
        .clk     (clk),
        .we      (bank_we),
        .addr    (bank_addr),
        .rd_addr (bank_rd_addr),
        .din     (bank_din),
        .dout    (bank_dout)
    );

    // Clear sequencer and round-robin pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rr_wr    <= 1'b0;
            rr_rd    <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_W'(DEPTH - 1)) begin
                        state <= RUN;
                    end
                end
                default: begin
                    if (clear) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end else begin
                        if (&wr_cand) rr_wr <= ~rr_wr;
                        if (&rd_cand) rr_rd <= ~rr_rd;
                    end
                end
            endcase
        end
    end

    // Read responses: capture the asynchronous DPO into the granted
    // requester's slice; other slices hold their last response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_gnt;
            for (int i = 0; i < NREQ; i++) begin
                if (rd_gnt[i]) begin
                    rsp_data[WIDTH*i +: WIDTH] <= bank_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_lutram_port_arbiter.sv
// Self-checking bench for lutram_port_arbiter: directed vector table, clear
// and reset sequences, and randomized traffic against a memory-array model.
module tb_lutram_port_arbiter;

    localparam int W = 8;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_we;
    logic [11:0]   req_addr;
    logic [2*W-1:0] req_wdata;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [2*W-1:0] rsp_data;
    logic          clear;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    lutram_port_arbiter #(
        .WIDTH (W),
        .LOC   ("")
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .clear     (clear),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bank contents, remaining clear cycles, pointers and
    // the response registers as seen by each requester.
    logic [W-1:0] m_mem [64];
    int           m_left;
    bit           m_rr_wr;
    bit           m_rr_rd;
    logic [1:0]   m_rv;
    logic [W-1:0] m_rd [2];

    typedef struct {
        logic [1:0]   v;
        logic [1:0]   we;
        logic [5:0]   a0;
        logic [5:0]   a1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         clr;
        logic [1:0]   er;
        logic [1:0]   erv;
        logic [W-1:0] ed0;
        logic [W-1:0] ed1;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [1:0] cand, input bit ptr);
        if (cand == 2'b11) return ptr ? 1 : 0;
        if (cand[0]) return 0;
        if (cand[1]) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_left  = 64;
        m_rr_wr = 1'b0;
        m_rr_rd = 1'b0;
        m_rv    = 2'b00;
        m_rd[0] = '0;
        m_rd[1] = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
    endtask

    // Called just after a falling edge: drive one cycle of inputs, check the
    // outputs against the model, advance the model, wait for the next fall.
    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [5:0] a0, input logic [5:0] a1,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic clr);
        int         w;
        int         r;
        logic [1:0] er;
        logic [5:0] a [2];
        logic [W-1:0] d [2];
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        clear     = clr;
        #1;
        w  = -1;
        r  = -1;
        er = 2'b00;
        if (m_left == 0 && !clr) begin
            w = winner(v & we, m_rr_wr);
            r = winner(v & ~we, m_rr_rd);
            if (w >= 0) er[w] = 1'b1;
            if (r >= 0) er[r] = 1'b1;
        end
        check("busy", busy, m_left > 0);
        check("req_ready", req_ready, er);
        check("rsp_valid", rsp_valid, m_rv);
        check("rsp_data0", rsp_data[W-1:0], m_rd[0]);
        check("rsp_data1", rsp_data[2*W-1:W], m_rd[1]);
        m_rv = 2'b00;
        if (m_left > 0) begin
            m_left--;
        end else if (clr) begin
            m_left = 64;
            foreach (m_mem[i]) m_mem[i] = '0;
        end else begin
            if (r >= 0) begin
                m_rv[r] = 1'b1;
                m_rd[r] = m_mem[a[r]];
            end
            if (w >= 0) m_mem[a[w]] = d[w];
            if ((v & we) == 2'b11) m_rr_wr = ~m_rr_wr;
            if ((v & ~we) == 2'b11) m_rr_rd = ~m_rr_rd;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must drop at once.
    task automatic do_reset();
        req_valid = 2'b11;
        req_we    = 2'b01;
        clear     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_busy", busy, 1'b1);
        check("rst_ready", req_ready, 2'b00);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_data", rsp_data, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count busy cycles with valid traffic offered; the model checks that
    // ready stays low throughout.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 200) begin
            step(2'b11, 2'b01, n[5:0], 6'(63 - n), 8'hEE, 8'h00, 1'b0);
            n++;
        end
        check(name, n, 64);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clear     = 1'b0;
        model_reset();

        tbl[0]  = '{2'b01, 2'b01, 6'd5, 6'd0, 8'hA5, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 8'h00};
        tbl[1]  = '{2'b10, 2'b00, 6'd0, 6'd5, 8'h00, 8'h00, 1'b0, 2'b10, 2'b00, 8'h00, 8'h00};
        tbl[2]  = '{2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 1'b0, 2'b00, 2'b10, 8'h00, 8'hA5};
        tbl[3]  = '{2'b11, 2'b11, 6'd1, 6'd2, 8'h11, 8'h22, 1'b0, 2'b01, 2'b00, 8'h00, 8'h00};
        tbl[4]  = '{2'b10, 2'b10, 6'd0, 6'd2, 8'h00, 8'h22, 1'b0, 2'b10, 2'b00, 8'h00, 8'h00};
        tbl[5]  = '{2'b11, 2'b11, 6'd1, 6'd2, 8'h11, 8'h22, 1'b0, 2'b10, 2'b00, 8'h00, 8'h00};
        tbl[6]  = '{2'b01, 2'b01, 6'd1, 6'd0, 8'h11, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 8'h00};
        tbl[7]  = '{2'b11, 2'b00, 6'd1, 6'd2, 8'h00, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 8'h00};
        tbl[8]  = '{2'b10, 2'b00, 6'd0, 6'd2, 8'h00, 8'h00, 1'b0, 2'b10, 2'b01, 8'h11, 8'h00};
        tbl[9]  = '{2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 1'b0, 2'b00, 2'b10, 8'h00, 8'h22};
        tbl[10] = '{2'b01, 2'b01, 6'd7, 6'd0, 8'h3C, 8'h00, 1'b0, 2'b01, 2'b00, 8'h00, 8'h00};
        tbl[11] = '{2'b11, 2'b01, 6'd7, 6'd7, 8'h5A, 8'h00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00};
        tbl[12] = '{2'b10, 2'b00, 6'd0, 6'd7, 8'h00, 8'h00, 1'b0, 2'b10, 2'b10, 8'h00, 8'h3C};
        tbl[13] = '{2'b00, 2'b00, 6'd0, 6'd0, 8'h00, 8'h00, 1'b0, 2'b00, 2'b10, 8'h00, 8'h5A};
        tbl[14] = '{2'b11, 2'b01, 6'd9, 6'd7, 8'hFF, 8'h00, 1'b0, 2'b11, 2'b00, 8'h00, 8'h00};
        tbl[15] = '{2'b10, 2'b00, 6'd0, 6'd9, 8'h00, 8'h00, 1'b1, 2'b00, 2'b10, 8'h00, 8'h5A};

        @(negedge clk);
        do_reset();

        // Power-on clear, then read back every address through requester 1.
        count_busy("poweron_busy_cycles");
        for (int a = 0; a < 64; a++) begin
            step(2'b10, 2'b00, 6'd0, 6'(a), '0, '0, 1'b0);
        end
        idle();

        // Directed vectors with hand-derived expectations.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].clr);
        end
        for (int i = 0; i < 16; i++) begin
            // Re-run of the expectations is not possible after the fact, so
            // the table is checked on a second pass after another full clear.
        end

        // Clear requested in the last table row: 64 busy cycles, then the
        // written address reads back as zero.
        count_busy("clear_busy_cycles");
        step(2'b10, 2'b00, 6'd0, 6'd9, '0, '0, 1'b0);
        idle();
        check("addr9_after_clear", rsp_data[2*W-1:W], 8'h00);

        // Second pass over the table, now also comparing hand-derived values.
        // Pointers are back at 0 only after reset, so reset first.
        do_reset();
        count_busy("reset_busy_cycles");
        for (int i = 0; i < 16; i++) begin
            req_valid = tbl[i].v;
            req_we    = tbl[i].we;
            req_addr  = {tbl[i].a1, tbl[i].a0};
            req_wdata = {tbl[i].d1, tbl[i].d0};
            clear     = tbl[i].clr;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, tbl[i].er);
            check($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].erv);
            if (tbl[i].erv[0]) check($sformatf("vec%0d_rsp0", i), rsp_data[W-1:0], tbl[i].ed0);
            if (tbl[i].erv[1]) check($sformatf("vec%0d_rsp1", i), rsp_data[2*W-1:W], tbl[i].ed1);
            step(tbl[i].v, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].clr);
        end
        count_busy("clear2_busy_cycles");

        // Randomized traffic with occasional clears; narrow address range
        // half the time to provoke same-address hazards.
        for (int n = 0; n < 600; n++) begin
            logic [5:0] ra0;
            logic [5:0] ra1;
            bit narrow;
            narrow = $urandom_range(0, 1) == 1;
            ra0 = narrow ? 6'($urandom_range(0, 3)) : 6'($urandom);
            ra1 = narrow ? 6'($urandom_range(0, 3)) : 6'($urandom);
            step(2'($urandom), 2'($urandom), ra0, ra1, 8'($urandom), 8'($urandom),
                 $urandom_range(0, 99) == 0);
        end

        // Reset 30 cycles into a requested clear restarts the fill from 0.
        for (int n = 0; n < 100 && m_left > 0; n++) idle();
        step(2'b00, 2'b00, 6'd0, 6'd0, '0, '0, 1'b1);
        for (int n = 0; n < 30; n++) idle();
        check("busy_mid_clear", busy, 1'b1);
        do_reset();
        count_busy("midclear_reset_busy_cycles");
        step(2'b10, 2'b00, 6'd0, 6'd0, '0, '0, 1'b0);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
